// File: rtl/msft_sram_arb_pkg.sv
// rtl/msft_sram_arb_pkg.sv - shared request/response types and address range helper
package msft_sram_arb_pkg;

  localparam int NUM_MASTERS    = 2;
  localparam int MAX_DATA_WIDTH = 33;

  typedef struct packed {
    logic [31:0]               addr;
    logic                      we;
    logic [3:0]                be;
    logic [MAX_DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] rdata;
    logic                      rerr;
  } rsp_t;

  // Limit is computed one bit wider so a bank ending at 2^32 does not wrap.
  function automatic logic in_range(input logic [31:0] addr, input logic [31:0] base,
                                    input logic [32:0] bytes);
    logic [32:0] limit;
    limit = {1'b0, base} + bytes;
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/msft_sram_arb_resp_slot.sv
// rtl/msft_sram_arb_resp_slot.sv - per-master response slot: bypass read data, hold under backpressure
module msft_sram_arb_resp_slot
  import msft_sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_i,
  input  logic                  gnt_i,
  input  logic                  is_read_i,
  input  logic                  rerr_i,
  input  logic                  rready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rerr_o,
  output logic                  elig_o
);

  logic                  inflight_q;
  logic                  is_read_q;
  logic                  rerr_q;
  logic                  held_q;
  rsp_t                  hold_q;
  logic [DATA_WIDTH-1:0] live_rdata;

  // inflight and held are mutually exclusive: a held slot blocks new grants until drained.
  assign rvalid_o = inflight_q | held_q;
  assign elig_o   = req_i & (~rvalid_o | rready_i);

  always_comb begin
    live_rdata = '0;
    if (inflight_q && is_read_q && !rerr_q) live_rdata = mem_rdata_i;
  end

  assign rdata_o = held_q ? hold_q.rdata[DATA_WIDTH-1:0] : live_rdata;
  assign rerr_o  = held_q ? hold_q.rerr : (inflight_q & rerr_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_q <= 1'b0;
      is_read_q  <= 1'b0;
      rerr_q     <= 1'b0;
      held_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      inflight_q <= gnt_i;
      if (gnt_i) begin
        is_read_q <= is_read_i;
        rerr_q    <= rerr_i;
      end
      held_q <= rvalid_o & ~rready_i;
      if (rvalid_o && !rready_i) hold_q <= '{rdata: MAX_DATA_WIDTH'(rdata_o), rerr: rerr_o};
    end
  end

  if (DATA_WIDTH < MAX_DATA_WIDTH) begin : g_pad
    logic unused_hold_pad;
    assign unused_hold_pad = ^hold_q.rdata[MAX_DATA_WIDTH-1:DATA_WIDTH];
  end

endmodule

// File: rtl/msft_sram_req_arbiter.sv
// rtl/msft_sram_req_arbiter.sv - two-master round-robin arbiter in front of a single-port SRAM
module msft_sram_req_arbiter
  import msft_sram_arb_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ADDR_BASE  = 32'h2000_0000,
  parameter logic [32:0] MEM_BYTES  = 33'h1_0000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  m0_req_i,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_rerr_o,
  input  logic                  m0_rready_i,
  input  logic                  m1_req_i,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_rerr_o,
  input  logic                  m1_rready_i,
  output logic                  mem_en_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   prio_q;
  req_t                   m0_req;
  req_t                   m1_req;
  req_t                   win;
  logic                   win_in_range;

  assign m0_req = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: MAX_DATA_WIDTH'(m0_wdata_i)};
  assign m1_req = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: MAX_DATA_WIDTH'(m1_wdata_i)};

  // prio_q = 0 means m0 wins a tie; grants are suppressed while reset is asserted.
  always_comb begin
    gnt = '0;
    if (rstn_i) begin
      if (elig[0] && (!elig[1] || !prio_q)) gnt[0] = 1'b1;
      else if (elig[1])                     gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)     prio_q <= 1'b0;
    else if (gnt[0]) prio_q <= 1'b1;
    else if (gnt[1]) prio_q <= 1'b0;
  end

  assign win          = gnt[1] ? m1_req : m0_req;
  assign win_in_range = in_range(win.addr, ADDR_BASE, MEM_BYTES);

  // Out-of-range accesses are still granted but never reach the SRAM.
  assign mem_en_o    = (|gnt) & win_in_range;
  assign mem_we_o    = mem_en_o & win.we;
  assign mem_be_o    = mem_we_o ? win.be : 4'h0;
  assign mem_addr_o  = mem_en_o ? win.addr : 32'h0;
  assign mem_wdata_o = mem_en_o ? win.wdata[DATA_WIDTH-1:0] : '0;

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  msft_sram_arb_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (m0_req_i),
    .gnt_i       (gnt[0]),
    .is_read_i   (~win.we),
    .rerr_i      (~win_in_range),
    .rready_i    (m0_rready_i),
    .mem_rdata_i (mem_rdata_i),
    .rvalid_o    (m0_rvalid_o),
    .rdata_o     (m0_rdata_o),
    .rerr_o      (m0_rerr_o),
    .elig_o      (elig[0])
  );

  msft_sram_arb_resp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_i       (m1_req_i),
    .gnt_i       (gnt[1]),
    .is_read_i   (~win.we),
    .rerr_i      (~win_in_range),
    .rready_i    (m1_rready_i),
    .mem_rdata_i (mem_rdata_i),
    .rvalid_o    (m1_rvalid_o),
    .rdata_o     (m1_rdata_o),
    .rerr_o      (m1_rerr_o),
    .elig_o      (elig[1])
  );

  if (DATA_WIDTH < MAX_DATA_WIDTH) begin : g_pad
    logic unused_wdata_pad;
    assign unused_wdata_pad = ^win.wdata[MAX_DATA_WIDTH-1:DATA_WIDTH];
  end

endmodule

// File: tb/tb_msft_sram_req_arbiter.sv
// tb/tb_msft_sram_req_arbiter.sv - self-checking bench for msft_sram_req_arbiter
module tb_msft_sram_req_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req    [2];
  logic [31:0] addr   [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] wdata  [2];
  logic        rready [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        rerr   [2];
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
  logic [3:0]  mem_be_o;

  int tests_run = 0;
  int fails = 0;

  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] env_word;

  bit          pv [2];
  bit          pe [2];
  logic [31:0] pd [2];
  bit          prio;
  bit          e_gnt [2];
  bit          e_en, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;

  msft_sram_req_arbiter dut (
    .clk_i(clk), .rstn_i(rst_n),
    .m0_req_i(req[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]), .m0_be_i(be[0]), .m0_wdata_i(wdata[0]),
    .m0_gnt_o(gnt[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]), .m0_rerr_o(rerr[0]),
    .m0_rready_i(rready[0]),
    .m1_req_i(req[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]), .m1_be_i(be[1]), .m1_wdata_i(wdata[1]),
    .m1_gnt_o(gnt[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]), .m1_rerr_o(rerr[1]),
    .m1_rready_i(rready[1]),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM environment: 1-cycle read latency, garbage on the data bus when not reading.
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) begin
      env_word = sram[mem_addr_o[15:2]];
      for (int b = 0; b < 4; b++) if (mem_be_o[b]) env_word[8*b +: 8] = mem_wdata_o[8*b +: 8];
      sram[mem_addr_o[15:2]] <= env_word;
      mem_rdata <= $urandom;
    end else if (mem_en_o) begin
      mem_rdata <= sram[mem_addr_o[15:2]];
    end else begin
      mem_rdata <= $urandom;
    end
  end

  function automatic bit ref_in_range(logic [31:0] a);
    return (a >= 32'h2000_0000) && (a < 32'h2001_0000);
  endfunction

  task automatic model_reset();
    pv[0] = 0; pv[1] = 0; prio = 0;
  endtask

  task automatic model_eval();
    bit el [2];
    int w;
    for (int m = 0; m < 2; m++) el[m] = req[m] && (!pv[m] || rready[m]);
    e_gnt[0] = el[0] && (!el[1] || prio == 0);
    e_gnt[1] = el[1] && !e_gnt[0];
    w = e_gnt[1] ? 1 : 0;
    e_en    = (e_gnt[0] || e_gnt[1]) && ref_in_range(addr[w]);
    e_we    = e_en && we[w];
    e_be    = e_we ? be[w] : 4'h0;
    e_addr  = addr[w];
    e_wdata = wdata[w];
  endtask

  task automatic model_commit();
    for (int m = 0; m < 2; m++) begin
      if (pv[m] && rready[m]) pv[m] = 0;
      if (e_gnt[m]) begin
        pv[m] = 1;
        pe[m] = !ref_in_range(addr[m]);
        pd[m] = (!pe[m] && !we[m]) ? ref_mem[addr[m][15:2]] : 32'h0;
        if (!pe[m] && we[m])
          for (int b = 0; b < 4; b++)
            if (be[m][b]) ref_mem[addr[m][15:2]][8*b +: 8] = wdata[m][8*b +: 8];
      end
    end
    if (e_gnt[0]) prio = 1;
    else if (e_gnt[1]) prio = 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m] = 0; addr[m] = 32'h0; we[m] = 0; be[m] = 4'h0; wdata[m] = 32'h0; rready[m] = 1;
    end
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    #3;
    tests_run++;
    if ({gnt[0], gnt[1], rvalid[0], rvalid[1], rerr[0], rerr[1], mem_en_o, mem_we_o} !== 8'h0 ||
        rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
      fails++; $display("FAIL reset_in got gnt=%b%b rv=%b%b en=%b exp all 0", gnt[0], gnt[1], rvalid[0], rvalid[1], mem_en_o);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      #3;
      tests_run++;
      if ({gnt[0], gnt[1], rvalid[0], rvalid[1], rerr[0], rerr[1], mem_en_o, mem_we_o} !== 8'h0 ||
          rdata[0] !== 32'h0 || rdata[1] !== 32'h0) begin
        fails++; $display("FAIL reset_idle cyc %0d got rv=%b%b en=%b exp 0", i, rvalid[0], rvalid[1], mem_en_o);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    req[0] = 1; addr[0] = 32'h2000_0010; we[0] = 1; be[0] = 4'hF; wdata[0] = 32'hDEAD_BEEF;
    #3;
    tests_run++;
    if ({gnt[0], mem_en_o, mem_we_o, mem_be_o} !== 7'b111_1111 || mem_addr_o !== 32'h2000_0010 ||
        mem_wdata_o !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL wr_issue got gnt=%b en=%b we=%b be=%h a=%h exp 1 1 1 f 20000010", gnt[0], mem_en_o, mem_we_o, mem_be_o, mem_addr_o);
    end
    tick();
    we[0] = 0;
    #3;
    tests_run++;
    if ({rvalid[0], rerr[0], gnt[0], mem_en_o, mem_we_o} !== 5'b10110 || rdata[0] !== 32'h0 || mem_be_o !== 4'h0) begin
      fails++; $display("FAIL wr_rsp_rd_issue got rv=%b err=%b gnt=%b we=%b rdata=%h exp 1 0 1 0 0", rvalid[0], rerr[0], gnt[0], mem_we_o, rdata[0]);
    end
    tick();
    req[0] = 0;
    #3;
    tests_run++;
    if (rvalid[0] !== 1'b1 || rerr[0] !== 1'b0 || rdata[0] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL rd_rsp got rv=%b err=%b rdata=%h exp 1 0 deadbeef", rvalid[0], rerr[0], rdata[0]);
    end
    tick();
    req[0] = 1; we[0] = 1; be[0] = 4'h0; addr[0] = 32'h2000_0020;
    #3;
    tests_run++;
    if ({rvalid[0], gnt[0], mem_en_o, mem_we_o, mem_be_o} !== 8'b0111_0000) begin
      fails++; $display("FAIL be0_write got rv=%b gnt=%b en=%b we=%b be=%h exp 0 1 1 1 0", rvalid[0], gnt[0], mem_en_o, mem_we_o, mem_be_o);
    end
    tick();
    req[0] = 0;
    #3;
    tests_run++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h0) begin
      fails++; $display("FAIL be0_rsp got rv=%b rdata=%h exp 1 0", rvalid[0], rdata[0]);
    end
    tick();
  endtask

  task automatic test_alternate();
    apply_reset();
    req[0] = 1; addr[0] = 32'h2000_0100;
    req[1] = 1; addr[1] = 32'h2000_0200;
    for (int i = 0; i < 8; i++) begin
      #3;
      tests_run++;
      if (gnt[0] !== (i % 2 == 0) || gnt[1] !== (i % 2 == 1) || mem_en_o !== 1'b1 ||
          mem_addr_o !== ((i % 2 == 0) ? 32'h2000_0100 : 32'h2000_0200)) begin
        fails++; $display("FAIL alternate cyc %0d got gnt=%b%b en=%b a=%h", i, gnt[0], gnt[1], mem_en_o, mem_addr_o);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    req[1] = 1; addr[1] = 32'h2000_0010; rready[1] = 0;
    #3;
    tests_run++;
    if (gnt[1] !== 1'b1) begin fails++; $display("FAIL bp_grant got %b exp 1", gnt[1]); end
    tick();
    req[0] = 1; addr[0] = 32'h2000_0100;
    for (int k = 1; k <= 3; k++) begin
      #3;
      tests_run++;
      if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hDEAD_BEEF || gnt[1] !== 1'b0 || gnt[0] !== 1'b1) begin
        fails++; $display("FAIL bp_hold cyc %0d got rv=%b rdata=%h gnt=%b%b exp 1 deadbeef 10", k, rvalid[1], rdata[1], gnt[0], gnt[1]);
      end
      tick();
    end
    req[0] = 0; rready[1] = 1;
    #3;
    tests_run++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hDEAD_BEEF || gnt[1] !== 1'b1) begin
      fails++; $display("FAIL bp_drain got rv=%b rdata=%h gnt=%b exp 1 deadbeef 1", rvalid[1], rdata[1], gnt[1]);
    end
    tick();
    req[1] = 0;
    #3;
    tests_run++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL bp_next got rv=%b rdata=%h exp 1 deadbeef", rvalid[1], rdata[1]);
    end
    tick();
    #3;
    tests_run++;
    if (rvalid[1] !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", rvalid[1]); end
    tick();
  endtask

  task automatic test_range();
    apply_reset();
    req[0] = 1; addr[0] = 32'h2001_0000;
    #3;
    tests_run++;
    if (gnt[0] !== 1'b1 || mem_en_o !== 1'b0) begin
      fails++; $display("FAIL oor_hi_issue got gnt=%b en=%b exp 1 0", gnt[0], mem_en_o);
    end
    tick();
    addr[0] = 32'h1FFF_FFFC;
    #3;
    tests_run++;
    if ({rvalid[0], rerr[0], gnt[0], mem_en_o} !== 4'b1110 || rdata[0] !== 32'h0) begin
      fails++; $display("FAIL oor_hi_rsp got rv=%b err=%b gnt=%b en=%b rdata=%h exp 1 1 1 0 0", rvalid[0], rerr[0], gnt[0], mem_en_o, rdata[0]);
    end
    tick();
    addr[0] = 32'h2000_FFFC;
    #3;
    tests_run++;
    if ({rvalid[0], rerr[0], gnt[0], mem_en_o} !== 4'b1111 || rdata[0] !== 32'h0) begin
      fails++; $display("FAIL oor_lo_rsp got rv=%b err=%b gnt=%b en=%b rdata=%h exp 1 1 1 1 0", rvalid[0], rerr[0], gnt[0], mem_en_o, rdata[0]);
    end
    tick();
    req[0] = 0;
    #3;
    tests_run++;
    if (rvalid[0] !== 1'b1 || rerr[0] !== 1'b0 || rdata[0] !== ref_mem[14'h3FFF]) begin
      fails++; $display("FAIL last_word got rv=%b err=%b rdata=%h exp 1 0 %h", rvalid[0], rerr[0], rdata[0], ref_mem[14'h3FFF]);
    end
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    req[0] = 1; addr[0] = 32'h2000_0010; rready[0] = 0;
    #3;
    tests_run++;
    if (gnt[0] !== 1'b1) begin fails++; $display("FAIL ar_grant got %b exp 1", gnt[0]); end
    tick();
    req[0] = 0;
    #3;
    tests_run++;
    if (rvalid[0] !== 1'b1) begin fails++; $display("FAIL ar_inflight got %b exp 1", rvalid[0]); end
    #1 rst_n = 0;
    model_reset();
    #1;
    tests_run++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      fails++; $display("FAIL ar_drop got rv=%b rdata=%h exp 0 0", rvalid[0], rdata[0]);
    end
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1; rready[0] = 1;
    for (int i = 0; i < 3; i++) begin
      #3;
      tests_run++;
      if (rvalid[0] !== 1'b0) begin fails++; $display("FAIL ar_stale cyc %0d got %b exp 0", i, rvalid[0]); end
      tick();
    end
    req[0] = 1; req[1] = 1; addr[1] = 32'h2000_0040;
    #3;
    tests_run++;
    if (gnt[0] !== 1'b1 || gnt[1] !== 1'b0) begin
      fails++; $display("FAIL ar_prio got gnt=%b%b exp 10", gnt[0], gnt[1]);
    end
    tick();
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [9:0] got_v, exp_v;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        int r;
        req[m]    = ($urandom_range(0, 9) < 7);
        we[m]     = ($urandom_range(0, 2) == 0);
        be[m]     = 4'($urandom);
        wdata[m]  = $urandom;
        rready[m] = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 19);
        if (r == 0)      addr[m] = 32'h2001_0000;
        else if (r == 1) addr[m] = 32'h1FFF_FFFC;
        else if (r == 2) addr[m] = 32'h2000_FFFC;
        else             addr[m] = 32'h2000_0000 + 32'($urandom_range(0, 15) * 4);
      end
      #3;
      model_eval();
      got_v = {gnt[0], gnt[1], rvalid[0], rvalid[1], mem_en_o, mem_we_o, mem_be_o};
      exp_v = {e_gnt[0], e_gnt[1], pv[0], pv[1], e_en, e_we, e_be};
      tests_run++;
      if (got_v !== exp_v) begin
        fails++; $display("FAIL rnd_ctrl cyc %0d got %b exp %b", i, got_v, exp_v);
      end
      for (int m = 0; m < 2; m++) if (pv[m]) begin
        tests_run++;
        if (rdata[m] !== pd[m] || rerr[m] !== pe[m]) begin
          fails++; $display("FAIL rnd_rsp%0d cyc %0d got %h/%b exp %h/%b", m, i, rdata[m], rerr[m], pd[m], pe[m]);
        end
      end
      if (e_en) begin
        tests_run++;
        if (mem_addr_o !== e_addr || (e_we && mem_wdata_o !== e_wdata)) begin
          fails++; $display("FAIL rnd_mem cyc %0d got %h/%h exp %h/%h", i, mem_addr_o, mem_wdata_o, e_addr, e_wdata);
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    mem_rdata = 32'h0;
    clear_inputs();
    rst_n = 0;
    #1;
    test_reset();
    test_write_read();
    test_alternate();
    test_backpressure();
    test_range();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
